md_unit: RTL and testbench

//   Multiply/divide unit for the pipelined MIPS core; sits in EX beside the ALU.

---
 rtl/md_defs.sv | 21 ++
 rtl/md_arith.sv | 29 ++
 rtl/md_unit.sv | 68 ++++++
 tb/tb_md_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/md_defs.sv
// md_defs: shared op encodings, FSM state codes and op-class helpers for the multiply/divide unit
package md_defs;
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;
  function automatic logic is_arith(input logic [2:0] op);
    return op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
  endfunction
  function automatic logic is_div(input logic [2:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit {hi,lo} result of the latched md op, plus divide-by-zero flag
module md_arith
  import md_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div0
);
  logic        sgn;
  logic [31:0] ua, ub, bs, q, r, qs, rs;
  logic [63:0] prod_s, prod_u;
  // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000
  always_comb begin
    sgn    = op == MD_DIV;
    ua     = (sgn && a[31]) ? -a : a;
    ub     = (sgn && b[31]) ? -b : b;
    bs     = (ub == '0) ? 32'd1 : ub;
    q      = ua / bs;
    r      = ua % bs;
    qs     = (sgn && (a[31] ^ b[31])) ? -q : q;
    rs     = (sgn && a[31]) ? -r : r;
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    res    = is_div(op) ? {rs, qs} : (op == MD_MULT ? prod_s : prod_u);
    div0   = is_div(op) && b == '0;
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/DIV unit owning HI/LO, with MTHI/MTLO and flush support
module md_unit
  import md_defs::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2((MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1);
  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] res;
  logic        div0, idle, accept, done, commit;
  md_arith u_arith (.op(op_q), .a(a_q), .b(b_q), .res(res), .div0(div0));
  // State and datapath registers; async reset aborts any op and clears HI/LO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  // Next state: cancel beats both a new start and a pending commit
  always_comb begin
    idle    = state_q == MD_IDLE;
    accept  = idle && start && !cancel && is_arith(md_op);
    done    = !idle && (cancel || cnt_q == '0);
    state_d = idle ? (accept ? MD_BUSY : MD_IDLE) : (done ? MD_IDLE : MD_BUSY);
  end
  // Outputs and datapath: latch operands on accept, count down, commit or apply MTHI/MTLO
  always_comb begin
    commit = !idle && !cancel && cnt_q == '0 && !div0;
    cnt_d  = accept ? (is_div(md_op) ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1))
                    : ((!idle && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q);
    op_d   = accept ? md_op : op_q;
    a_d    = accept ? a : a_q;
    b_d    = accept ? b : b_q;
    hi_d   = commit ? res[63:32] : ((idle && start && !cancel && md_op == MD_MTHI) ? a : hi_q);
    lo_d   = commit ? res[31:0]  : ((idle && start && !cancel && md_op == MD_MTLO) ? a : lo_q);
    busy   = !idle;
    hi     = hi_q;
    lo     = lo_q;
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table vectors, corner sequences and randomized ops against a behavioural HI/LO model
module tb_md_unit;
  logic        clk = 0, reset_n = 0, start = 0, cancel = 0, busy;
  logic [2:0]  md_op = 0;
  logic [31:0] a = 0, b = 0, hi, lo;
  logic [31:0] m_hi = 0, m_lo = 0;
  int          checks = 0, failures = 0;

  md_unit dut (.clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op), .a(a), .b(b),
               .cancel(cancel), .busy(busy), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural reference: result of one op applied to the architectural HI/LO
  task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint          sp, sq, sr;
    longint unsigned up;
    case (op)
      3'd0: begin sp = longint'($signed(x)) * longint'($signed(y)); {m_hi, m_lo} = sp; end
      3'd1: begin up = longint'({32'd0, x}) * longint'({32'd0, y}); {m_hi, m_lo} = up; end
      3'd2: if (y != 0) begin
        sq = longint'($signed(x)) / longint'($signed(y));
        sr = longint'($signed(x)) % longint'($signed(y));
        m_lo = sq[31:0];
        m_hi = sr[31:0];
      end
      3'd3: if (y != 0) begin m_lo = x / y; m_hi = x % y; end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    start = 1; md_op = op; a = x; b = y;
    @(posedge clk); #1;
    start = 0; a = $urandom; b = $urandom;
  endtask

  // Issue an op, check busy for exactly its latency, then check HI/LO against the model
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    int n;
    n = (op == 3'd0 || op == 3'd1) ? 5 : ((op == 3'd2 || op == 3'd3) ? 10 : 0);
    model(op, x, y);
    issue(op, x, y);
    for (int k = 0; k < n; k++) begin
      chk("busy_during", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  logic [31:0] sv_hi, sv_lo;
  logic [2:0]  rop;
  logic [31:0] ra, rb;

  initial begin
    tbl[0] = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    tbl[1] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[4] = '{3'd4, 32'h00001234, 32'd0,        32'h00001234, 32'h80000000};
    tbl[5] = '{3'd3, 32'd77,       32'd0,        32'h00001234, 32'h80000000};
    tbl[6] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b);
      chk($sformatf("tbl%0d_hi", i), hi, tbl[i].hi);
      chk($sformatf("tbl%0d_lo", i), lo, tbl[i].lo);
    end
    // start while busy (arith and MT ops) must not disturb the DIVU in flight
    model(3'd3, 32'd100, 32'd7);
    issue(3'd3, 32'd100, 32'd7);
    for (int k = 0; k < 10; k++) begin
      chk("ign_busy", {31'd0, busy}, 32'd1);
      if (k == 3) begin start = 1; md_op = 3'd0; a = 32'd3; b = 32'd3; end
      if (k == 6) begin start = 1; md_op = 3'd5; a = 32'd55; end
      @(posedge clk); #1;
      start = 0;
    end
    chk("ign_busy_end", {31'd0, busy}, 32'd0);
    chk("ign_hi", hi, 32'd2);
    chk("ign_lo", lo, 32'd14);
    // cancel in the third busy cycle of a MULT: no commit
    sv_hi = hi; sv_lo = lo;
    issue(3'd0, 32'd7, 32'd9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("cx_busy_pre", {31'd0, busy}, 32'd1);
    cancel = 1;
    @(posedge clk); #1;
    cancel = 0;
    chk("cx_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("cx_hi", hi, sv_hi);
    chk("cx_lo", lo, sv_lo);
    // cancel together with start in IDLE: start dropped
    cancel = 1;
    issue(3'd4, 32'hDEAD, 32'd0);
    cancel = 0;
    chk("cs_busy", {31'd0, busy}, 32'd0);
    chk("cs_hi", hi, sv_hi);
    issue(3'd1, 32'd3, 32'd4);
    cancel = 1;
    @(posedge clk); #1;
    cancel = 0;
    chk("cs2_busy", {31'd0, busy}, 32'd0);
    chk("cs2_lo", lo, sv_lo);
    // randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom);
      if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 9) == 0) rb = 32'hFFFFFFFF;
      run_op(rop, ra, rb);
    end
    // async reset in the middle of a DIV clears everything at once
    run_op(3'd4, 32'hAAAA5555, 32'd0);
    run_op(3'd5, 32'h5555AAAA, 32'd0);
    issue(3'd2, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_hi", hi, 32'd0);
    chk("ar_lo", lo, 32'd0);
    m_hi = 0; m_lo = 0;
    @(negedge clk); reset_n = 1;
    run_op(3'd1, 32'd6, 32'd7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
